// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: 640x480@60 defaults and
// the helper that sums the four segments of one axis into its total count.
package vga_timing_pkg;

    localparam int DEF_CNT_W    = 10;
    localparam int DEF_CLK_DIV  = 4;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Total positions on one axis: active + front porch + sync + back porch.
    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pulse_delay.sv
// Enable-gated shift register used to delay the sync/enable bundle so it
// lines up with a pipelined renderer. Depth 0 collapses to a plain wire.
module vga_pulse_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = &{1'b0, clk, reset, i_en};
        assign o_q      = i_d;
    end else begin : g_shift
        logic [WIDTH-1:0] r_stage [DEPTH];

        // Shift one stage per enable; reset loads the idle pattern everywhere.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
            end else if (i_en) begin
                r_stage[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock-enable divider, pixel/line counters,
// registered sync/active decode, line/frame strobes, frame counter and an
// optional delay line on the syncs and display enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int DELAY    = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pixelTick,
    output logic             horizontalVGA,
    output logic             verticalVGA,
    output logic             videoActive,
    output logic [CNT_W-1:0] pixelX,
    output logic [CNT_W-1:0] pixelY,
    output logic             lineStart,
    output logic             frameStart,
    output logic [15:0]      frameCount
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Totals must be representable (the sync end may equal the total).
    if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (DELAY < 0 || DELAY > 8) begin : g_bad_delay
        $error("vga_timing_gen: DELAY must be 0..8");
    end

    // Sync output level for a position: pol inside [beg, fin), idle otherwise.
    function automatic logic sync_level(input logic [CNT_W-1:0] pos,
                                        input logic [CNT_W-1:0] beg,
                                        input logic [CNT_W-1:0] fin,
                                        input logic             pol);
        return (pos >= beg && pos < fin) ? pol : ~pol;
    endfunction

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic [CNT_W-1:0] w_x_next;
    logic [CNT_W-1:0] w_y_next;
    logic             w_x_wrap;
    logic             w_frame_wrap;
    logic             r_hs;
    logic             r_vs;
    logic             r_va;
    logic             r_line_start;
    logic             r_frame_start;
    logic [15:0]      r_frame_cnt;
    logic [2:0]       w_dly_out;

    assign w_tick = (r_div_cnt == DIV_LAST);

    // Pixel-clock-enable divider: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + DIV_W'(1);
    end

    // Position after the next tick; decode uses it so it never lags the counters.
    always_comb begin
        w_x_wrap     = (r_x == H_LAST);
        w_x_next     = w_x_wrap ? '0 : r_x + CNT_W'(1);
        w_y_next     = r_y;
        if (w_x_wrap) w_y_next = (r_y == V_LAST) ? '0 : r_y + CNT_W'(1);
        w_frame_wrap = (w_x_next == '0) && (w_y_next == '0);
    end

    // Counters and registered region decode, advanced together on each tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x  <= H_LAST;
            r_y  <= V_LAST;
            r_hs <= ~H_POL;
            r_vs <= ~V_POL;
            r_va <= 1'b0;
        end else if (w_tick) begin
            r_x  <= w_x_next;
            r_y  <= w_y_next;
            r_hs <= sync_level(w_x_next, H_SYNC_BEG, H_SYNC_END, H_POL);
            r_vs <= sync_level(w_y_next, V_SYNC_BEG, V_SYNC_END, V_POL);
            r_va <= (w_x_next < H_ACT) && (w_y_next < V_ACT);
        end
    end

    // One-clock line/frame strobes and the frame counter, on the entering tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_line_start  <= w_tick && (w_x_next == '0);
            r_frame_start <= w_tick && w_frame_wrap;
            if (w_tick && w_frame_wrap) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    vga_pulse_delay #(
        .WIDTH   (3),
        .DEPTH   (DELAY),
        .RST_VAL ({~H_POL, ~V_POL, 1'b0})
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_tick),
        .i_d   ({r_hs, r_vs, r_va}),
        .o_q   (w_dly_out)
    );

    assign pixelTick     = w_tick;
    assign horizontalVGA = w_dly_out[2];
    assign verticalVGA   = w_dly_out[1];
    assign videoActive   = w_dly_out[0];
    assign pixelX        = r_x;
    assign pixelY        = r_y;
    assign lineStart     = r_line_start;
    assign frameStart    = r_frame_start;
    assign frameCount    = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (default mode, default with
// DELAY=2, a tiny CLK_DIV=1 mode, a small delayed mode) checked against a
// closed-form position model every cycle, plus a vector table and
// hand-written reset sequences.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        tick;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        va;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int div;
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hp, vp;
        int dly;
    } mode_t;

    typedef struct {
        int   inst;
        int   k;
        obs_t e;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   k     = 0;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mode_t modes [4];
    vec_t  vq [$];

    logic        tick [4];
    logic        hs   [4];
    logic        vs   [4];
    logic        va   [4];
    logic [9:0]  px   [4];
    logic [9:0]  py   [4];
    logic        ls   [4];
    logic        fs   [4];
    logic [15:0] fcnt [4];

    always #5 clk = ~clk;

    // Clock edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
    end

    vga_timing_gen u_def (
        .clk(clk), .reset(reset), .pixelTick(tick[0]), .horizontalVGA(hs[0]),
        .verticalVGA(vs[0]), .videoActive(va[0]), .pixelX(px[0]), .pixelY(py[0]),
        .lineStart(ls[0]), .frameStart(fs[0]), .frameCount(fcnt[0]));

    vga_timing_gen #(.DELAY(2)) u_dly (
        .clk(clk), .reset(reset), .pixelTick(tick[1]), .horizontalVGA(hs[1]),
        .verticalVGA(vs[1]), .videoActive(va[1]), .pixelX(px[1]), .pixelY(py[1]),
        .lineStart(ls[1]), .frameStart(fs[1]), .frameCount(fcnt[1]));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
    ) u_tiny (
        .clk(clk), .reset(reset), .pixelTick(tick[2]), .horizontalVGA(hs[2]),
        .verticalVGA(vs[2]), .videoActive(va[2]), .pixelX(px[2]), .pixelY(py[2]),
        .lineStart(ls[2]), .frameStart(fs[2]), .frameCount(fcnt[2]));

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(20), .H_FP(2), .H_SYNC(4), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2), .H_POL(1'b1), .V_POL(1'b0),
        .DELAY(1)
    ) u_med (
        .clk(clk), .reset(reset), .pixelTick(tick[3]), .horizontalVGA(hs[3]),
        .verticalVGA(vs[3]), .videoActive(va[3]), .pixelX(px[3]), .pixelY(py[3]),
        .lineStart(ls[3]), .frameStart(fs[3]), .frameCount(fcnt[3]));

    function automatic obs_t mk(input int t, input int x, input int y, input int h,
                                input int v, input int a, input int l, input int f,
                                input int c);
        obs_t o;
        o.tick = t[0]; o.x = 10'(x); o.y = 10'(y); o.hs = h[0]; o.vs = v[0];
        o.va = a[0]; o.ls = l[0]; o.fs = f[0]; o.fc = 16'(c);
        return o;
    endfunction

    function automatic mode_t mk_mode(input int div, input int ha, input int hfp,
                                      input int hsw, input int hbp, input int va_,
                                      input int vfp, input int vsw, input int vbp,
                                      input bit hp, input bit vp, input int dly);
        mode_t m;
        m.div = div; m.ha = ha; m.hfp = hfp; m.hsw = hsw; m.hbp = hbp;
        m.va = va_; m.vfp = vfp; m.vsw = vsw; m.vbp = vbp;
        m.hp = hp; m.vp = vp; m.dly = dly;
        return m;
    endfunction

    // Closed-form expectation: after kk clock edges, floor(kk/div) ticks have
    // happened; tick number t lands on raster position t-1 of the frame.
    function automatic obs_t model(input mode_t m, input int kk_in, input bit in_rst);
        obs_t o;
        int ht, vt, tot, kk, t, p, td, pd, xd, yd;
        bit on_edge;
        ht = m.ha + m.hfp + m.hsw + m.hbp;
        vt = m.va + m.vfp + m.vsw + m.vbp;
        tot = ht * vt;
        kk = in_rst ? 0 : kk_in;
        t = kk / m.div;
        p = (t + tot - 1) % tot;
        on_edge = (kk > 0) && (kk % m.div == 0);
        o.tick = ((kk % m.div) == (m.div - 1));
        o.x  = 10'(p % ht);
        o.y  = 10'(p / ht);
        o.ls = on_edge && (p % ht == 0);
        o.fs = on_edge && (p == 0);
        o.fc = (t == 0) ? 16'd0 : 16'(((t - 1) / tot + 1) % 65536);
        td = t - m.dly;
        if (td <= 0) begin
            o.hs = ~m.hp; o.vs = ~m.vp; o.va = 1'b0;
        end else begin
            pd = (td - 1) % tot;
            xd = pd % ht;
            yd = pd / ht;
            o.va = (xd < m.ha) && (yd < m.va);
            o.hs = (xd >= m.ha + m.hfp && xd < m.ha + m.hfp + m.hsw) ? m.hp : ~m.hp;
            o.vs = (yd >= m.va + m.vfp && yd < m.va + m.vfp + m.vsw) ? m.vp : ~m.vp;
        end
        return o;
    endfunction

    function automatic obs_t get_obs(input int i);
        return mk(int'(tick[i]), int'(px[i]), int'(py[i]), int'(hs[i]), int'(vs[i]),
                  int'(va[i]), int'(ls[i]), int'(fs[i]), int'(fcnt[i]));
    endfunction

    task automatic check_obs(input string name, input int inst, input obs_t exp);
        obs_t act;
        act = get_obs(inst);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d k=%0d: got tick=%0b x=%0d y=%0d hs=%0b vs=%0b va=%0b ls=%0b fs=%0b fc=%0d; want tick=%0b x=%0d y=%0d hs=%0b vs=%0b va=%0b ls=%0b fs=%0b fc=%0d",
                     name, inst, k, act.tick, act.x, act.y, act.hs, act.vs, act.va,
                     act.ls, act.fs, act.fc, exp.tick, exp.x, exp.y, exp.hs, exp.vs,
                     exp.va, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic wait_k(input int target);
        int guard;
        guard = 0;
        while (k < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (k != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_k: reached k=%0d, wanted k=%0d", k, target);
        end
    endtask

    task automatic add_vec(input int inst, input int kk, input obs_t e);
        vec_t v;
        v.inst = inst; v.k = kk; v.e = e;
        vq.push_back(v);
    endtask

    // Every cycle, every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) check_obs("model", i, model(modes[i], k, !reset));
        end
    end

    initial begin
        int guard;
        modes[0] = mk_mode(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0);
        modes[1] = mk_mode(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2);
        modes[2] = mk_mode(1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1, 0);
        modes[3] = mk_mode(2, 20, 2, 4, 4, 12, 2, 2, 2, 1'b1, 1'b0, 1);

        //        inst  k     tick  x    y  hs vs va ls fs fc
        add_vec(0,    1, mk(0, 799, 524, 1, 1, 0, 0, 0, 0));
        add_vec(2,    1, mk(1,   0,   0, 0, 0, 1, 1, 1, 1));
        add_vec(0,    3, mk(1, 799, 524, 1, 1, 0, 0, 0, 0));
        add_vec(0,    4, mk(0,   0,   0, 1, 1, 1, 1, 1, 1));
        add_vec(0,    5, mk(0,   0,   0, 1, 1, 1, 0, 0, 1));
        add_vec(0,    7, mk(1,   0,   0, 1, 1, 1, 0, 0, 1));
        add_vec(0,    8, mk(0,   1,   0, 1, 1, 1, 0, 0, 1));
        add_vec(2,   10, mk(1,   9,   0, 1, 0, 0, 0, 0, 1));
        add_vec(2,   12, mk(1,  11,   0, 0, 0, 0, 0, 0, 1));
        add_vec(2,   13, mk(1,   0,   1, 0, 0, 1, 1, 0, 1));
        add_vec(2,   61, mk(1,   0,   5, 0, 1, 0, 1, 0, 1));
        add_vec(2,   85, mk(1,   0,   0, 0, 0, 1, 1, 1, 2));
        add_vec(0, 2560, mk(0, 639,   0, 1, 1, 1, 0, 0, 1));
        add_vec(1, 2564, mk(0, 640,   0, 1, 1, 1, 0, 0, 1));
        add_vec(0, 2564, mk(0, 640,   0, 1, 1, 0, 0, 0, 1));
        add_vec(1, 2572, mk(0, 642,   0, 1, 1, 0, 0, 0, 1));
        add_vec(0, 2624, mk(0, 655,   0, 1, 1, 0, 0, 0, 1));
        add_vec(0, 2628, mk(0, 656,   0, 0, 1, 0, 0, 0, 1));
        add_vec(1, 2628, mk(0, 656,   0, 1, 1, 0, 0, 0, 1));
        add_vec(1, 2635, mk(1, 657,   0, 1, 1, 0, 0, 0, 1));
        add_vec(1, 2636, mk(0, 658,   0, 0, 1, 0, 0, 0, 1));
        add_vec(0, 3008, mk(0, 751,   0, 0, 1, 0, 0, 0, 1));
        add_vec(0, 3012, mk(0, 752,   0, 1, 1, 0, 0, 0, 1));
        add_vec(0, 3200, mk(0, 799,   0, 1, 1, 0, 0, 0, 1));
        add_vec(0, 3204, mk(0,   0,   1, 1, 1, 1, 1, 0, 1));

        // Power-on reset and reset-state checks.
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check_obs("rst_def",  0, mk(0, 799, 524, 1, 1, 0, 0, 0, 0));
        check_obs("rst_dly",  1, mk(0, 799, 524, 1, 1, 0, 0, 0, 0));
        check_obs("rst_tiny", 2, mk(1,  11,   6, 0, 0, 0, 0, 0, 0));
        check_obs("rst_med",  3, mk(0,  29,  17, 0, 1, 0, 0, 0, 0));
        reset = 1'b1;

        // Vector table, in ascending clock-edge order.
        foreach (vq[i]) begin
            wait_k(vq[i].k);
            check_obs($sformatf("vec%0d", i), vq[i].inst, vq[i].e);
        end

        // Asynchronous reset mid-frame on the small mode at (15, 9).
        guard = 0;
        while (!(px[3] == 10'd15 && py[3] == 10'd9) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL midframe_wait: med never reached (15,9), at (%0d,%0d)", px[3], py[3]);
        end
        #2 reset = 1'b0;
        #1;
        check_obs("midrst_med", 3, mk(0, 29, 17, 0, 1, 0, 0, 0, 0));
        check_obs("midrst_def", 0, mk(0, 799, 524, 1, 1, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_k(1);
        check_obs("rel_med_k1", 3, mk(1, 29, 17, 0, 1, 0, 0, 0, 0));
        wait_k(2);
        check_obs("rel_med_k2", 3, mk(0, 0, 0, 0, 1, 0, 1, 1, 1));
        wait_k(4);
        check_obs("rel_med_k4", 3, mk(0, 1, 0, 0, 1, 1, 0, 0, 1));
        check_obs("rel_def_k4", 0, mk(0, 0, 0, 1, 1, 1, 1, 1, 1));

        // Random run lengths with asynchronous resets dropped between edges.
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(40, 2500)) @(negedge clk);
            @(posedge clk);
            #($urandom_range(1, 3));
            reset = 1'b0;
            #1;
            for (int i = 0; i < 4; i++) check_obs("rnd_rst", i, model(modes[i], 0, 1'b1));
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset = 1'b1;
        end
        repeat (1500) @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator. It produces the sync pulses, a display-enable signal and pixel coordinates for any mode defined by active/front-porch/sync/back-porch counts. It includes an internal pixel-clock-enable divider, selectable sync polarity, line and frame strobes, a frame counter, and a configurable sync/enable delay line that aligns the syncs with a pipelined pixel renderer. It sits between the board clock and the renderer/colour output stage and is the timing source for all screen drawing.

Parameters:
CNT_W, 10, width of the pixelX/pixelY counters; H_TOTAL and V_TOTAL must fit, otherwise elaboration fails
CLK_DIV, 4, system clocks per pixel (1 = a tick every clock; 4 gives 25 MHz from 100 MHz)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, in pixels
H_SYNC, 96, horizontal sync width, in pixels
H_BP, 48, horizontal back porch, in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vertical sync width, in lines
V_BP, 33, vertical back porch, in lines
H_POL, 0, active level of the hsync pulse
V_POL, 0, active level of the vsync pulse
DELAY, 0, number of pixel ticks (0..8) of delay on horizontalVGA, verticalVGA and videoActive

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pixelTick  out  1  pixel enable; combinational decode of the divider register
horizontalVGA  out  1  hsync at H_POL polarity, delayed by DELAY ticks
verticalVGA  out  1  vsync at V_POL polarity, delayed by DELAY ticks
videoActive  out  1  high inside the visible region, delayed by DELAY ticks
pixelX  out  CNT_W  horizontal counter, 0..H_TOTAL-1 (undelayed)
pixelY  out  CNT_W  vertical counter, 0..V_TOTAL-1 (undelayed)
lineStart  out  1  1-clk strobe when pixelX enters 0
frameStart  out  1  1-clk strobe when (pixelX, pixelY) enters (0, 0)
frameCount  out  16  count of frames started, wraps modulo 2^16

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL is formed the same way (default 525).
- Region order on each axis: active, then front porch, then sync, then back porch.
- Divider: divCnt counts 0..CLK_DIV-1 and wraps; pixelTick = (divCnt == CLK_DIV-1).
- Counters change only on clock edges where pixelTick is high:
  - pixelX wraps from H_TOTAL-1 to 0.
  - pixelY increments only on a pixelX wrap, and wraps from V_TOTAL-1 to 0.
  - No count ever reaches H_TOTAL or V_TOTAL (exactly H_TOTAL pixels per line).
- Decode is registered and updated in the same edge as the counters, so it matches the current counter values with zero lag:
  - videoActive: pixelX < H_ACTIVE and pixelY < V_ACTIVE.
  - hsync: active while H_ACTIVE+H_FP ≤ pixelX < H_ACTIVE+H_FP+H_SYNC.
  - vsync: active while V_ACTIVE+V_FP ≤ pixelY < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Strobes:
  - lineStart and frameStart are registered, high for exactly one clk after the tick edge that enters the position.
  - frameCount increments on that same edge.
  - Strobe width is one clk, not one pixel.
- Delay line: DELAY-stage shift register on {hsync, vsync, videoActive}, advancing only on pixelTick. With DELAY=0 it is a direct path. pixelX, pixelY and the strobes are never delayed.
- Reset (asynchronous, active-low), effective immediately even mid-line:
  - divCnt = 0; pixelX = H_TOTAL-1; pixelY = V_TOTAL-1.
  - videoActive = 0; horizontalVGA = ~H_POL; verticalVGA = ~V_POL.
  - All delay stages hold these inactive values.
  - lineStart = frameStart = 0; frameCount = 0.
  - The first tick after release wraps to (0, 0) and fires lineStart, frameStart and frameCount = 1.
- Changing mode parameters requires re-elaboration; there is no runtime mode switching.

Decomposition:
- Package vga_timing_pkg: 640x480@60 default constants, and a function computing TOTAL from the four segment counts.
- Sub-module vga_pulse_delay: parametrised width/depth shift register with enable, used for the DELAY line; a depth-0 generate gives a wire-through.

Test Plan:
- Defaults, release reset: clock edges 1-3 give pixelTick=0; on edge 4 pixelX/pixelY go from (799, 524) to (0, 0), frameStart=1 for one clk, frameCount=1, videoActive=1.
- hsync window: pixelX 655→656 drives horizontalVGA 1→0; 751→752 drives it 0→1. videoActive is 0 from pixelX=640 and back to 1 at the next pixelX=0 on an active line.
- vsync and frame wrap: verticalVGA=0 only for pixelY=490 and 491. At (799, 524)→(0, 0), frameStart and lineStart each pulse for one clk and frameCount increments by 1.
- DELAY=2, CLK_DIV=4: horizontalVGA falls exactly 2 pixelTicks (8 clocks) after pixelX reaches 656, while pixelX itself is undelayed.
- CLK_DIV=1, H=8/1/2/1, V=4/1/1/1, H_POL=V_POL=1: line period is 12 clocks and frame period is 84 clocks. hsync is high for pixelX 9-10 and vsync is high for line 5.
- Assert reset mid-frame, at (300, 200) between clock edges: outputs take their reset values in the same cycle without a clock edge. After release, the full first-tick sequence repeats and frameCount restarts at 1.
